// File: rtl/pin_io_sync.sv
// Pad-side I/O front end: per-pin input synchroniser, optional glitch filter,
// registered pad outputs and edge pulses. Define PIN_IO_FILTER_EN to build the filter.

module pin_io_sync_lane #(
    parameter int   SYNC_STAGES   = 2,
`ifdef PIN_IO_FILTER_EN
    parameter int   FILTER_CYCLES = 4,
`endif
    parameter logic INIT_BIT      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin_out,
    input  logic i_pin_dir,
    input  logic i_pad_in,
    output logic o_pad_out,
    output logic o_pad_oe,
    output logic o_pin_in,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pad_out;
    logic                   r_pad_oe;
    logic                   r_prev;
    logic                   r_pdir;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_level;
    logic                   w_pin_in;
    logic                   w_dir_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_in};
        end
    end

`ifdef PIN_IO_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_filt;

    assign w_cnt_inc = r_cnt + CW'(1);

    // A new level is accepted only after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_filt <= INIT_BIT;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_cnt  <= '0;
        end else if (w_cnt_inc == CW'(FILTER_CYCLES)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_cnt  <= '0;
        end else begin
            r_cnt  <= w_cnt_inc;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    // Output pins read back their own data with no latency.
    assign w_pin_in     = i_pin_dir ? i_pin_out : w_level;
    assign w_dir_stable = ~(i_pin_dir ^ r_pdir);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pad_out <= 1'b0;
            r_pad_oe  <= 1'b0;
            r_prev    <= INIT_BIT;
            r_pdir    <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_pad_out <= i_pin_out;
            r_pad_oe  <= i_pin_dir;
            r_prev    <= w_pin_in;
            r_pdir    <= i_pin_dir;
            r_rise    <= w_pin_in & ~r_prev & w_dir_stable;
            r_fall    <= ~w_pin_in & r_prev & w_dir_stable;
        end
    end

    assign o_pad_out = r_pad_out;
    assign o_pad_oe  = r_pad_oe;
    assign o_pin_in  = w_pin_in;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
endmodule

module pin_io_sync #(
    parameter int               NPINS         = 32,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [NPINS-1:0] INIT          = {NPINS{1'b0}}
) (
    input  logic             clock_160,
    input  logic             inp_resn,
    input  logic [NPINS-1:0] pin_out,
    input  logic [NPINS-1:0] pin_dir,
    input  logic [NPINS-1:0] pad_in,
    output logic [NPINS-1:0] pad_out,
    output logic [NPINS-1:0] pad_oe,
    output logic [NPINS-1:0] pin_in,
    output logic [NPINS-1:0] pin_rise,
    output logic [NPINS-1:0] pin_fall
);
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pin_io_sync: SYNC_STAGES must be at least 2");
    end

    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("pin_io_sync: FILTER_CYCLES must be at least 1");
    end

    for (genvar g = 0; g < NPINS; g++) begin : g_pin
        pin_io_sync_lane #(
            .SYNC_STAGES   (SYNC_STAGES),
`ifdef PIN_IO_FILTER_EN
            .FILTER_CYCLES (FILTER_CYCLES),
`endif
            .INIT_BIT      (INIT[g])
        ) u_lane (
            .i_clk     (clock_160),
            .i_rst_n   (inp_resn),
            .i_pin_out (pin_out[g]),
            .i_pin_dir (pin_dir[g]),
            .i_pad_in  (pad_in[g]),
            .o_pad_out (pad_out[g]),
            .o_pad_oe  (pad_oe[g]),
            .o_pin_in  (pin_in[g]),
            .o_rise    (pin_rise[g]),
            .o_fall    (pin_fall[g])
        );
    end
endmodule

// File: tb/tb_pin_io_sync.sv
// Self-checking bench for pin_io_sync: directed scenarios plus random traffic against
// a history-window reference model. Follows PIN_IO_FILTER_EN like the design.

module tb_pin_io_sync;
    localparam int               NPINS         = 32;
    localparam int               SYNC_STAGES   = 2;
    localparam int               FILTER_CYCLES = 4;
    localparam logic [NPINS-1:0] INIT          = '0;
`ifdef PIN_IO_FILTER_EN
    localparam bit               FILT_EN       = 1'b1;
`else
    localparam bit               FILT_EN       = 1'b0;
`endif
    // Edges from first pad sample until pin_in shows the new level.
    localparam int               LAT           = SYNC_STAGES + (FILT_EN ? FILTER_CYCLES : 0);

    logic             clock_160 = 1'b0;
    logic             inp_resn;
    logic [NPINS-1:0] pin_out;
    logic [NPINS-1:0] pin_dir;
    logic [NPINS-1:0] pad_in;
    logic [NPINS-1:0] pad_out;
    logic [NPINS-1:0] pad_oe;
    logic [NPINS-1:0] pin_in;
    logic [NPINS-1:0] pin_rise;
    logic [NPINS-1:0] pin_fall;

    int total = 0;
    int bad   = 0;

    pin_io_sync #(
        .NPINS         (NPINS),
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .INIT          (INIT)
    ) dut (
        .clock_160 (clock_160),
        .inp_resn  (inp_resn),
        .pin_out   (pin_out),
        .pin_dir   (pin_dir),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .pin_in    (pin_in),
        .pin_rise  (pin_rise),
        .pin_fall  (pin_fall)
    );

    always #5 clock_160 = ~clock_160;

    // Reference model: pad samples since reset, sync samples seen by each edge.
    logic [NPINS-1:0] pad_hist[$];
    logic [NPINS-1:0] sync_hist[$];
    logic [NPINS-1:0] m_filt, m_prev_in, m_prev_dir, m_pad_out, m_pad_oe, m_rise, m_fall;

    function automatic logic [NPINS-1:0] m_sync();
        if (pad_hist.size() >= SYNC_STAGES) return pad_hist[pad_hist.size() - SYNC_STAGES];
        return INIT;
    endfunction

    function automatic logic [NPINS-1:0] m_pin_in();
        logic [NPINS-1:0] lvl;
        lvl = FILT_EN ? m_filt : m_sync();
        return (pin_dir & pin_out) | (~pin_dir & lvl);
    endfunction

    task automatic model_reset();
        pad_hist.delete();
        sync_hist.delete();
        m_filt     = INIT;
        m_prev_in  = INIT;
        m_prev_dir = '0;
        m_pad_out  = '0;
        m_pad_oe   = '0;
        m_rise     = '0;
        m_fall     = '0;
    endtask

    task automatic model_edge();
        logic [NPINS-1:0] now_in, now_sync;
        bit               all_new;
        if (!inp_resn) begin
            model_reset();
            return;
        end
        now_in   = m_pin_in();
        now_sync = m_sync();
        for (int i = 0; i < NPINS; i++) begin
            m_rise[i] = now_in[i] && !m_prev_in[i] && (pin_dir[i] == m_prev_dir[i]);
            m_fall[i] = !now_in[i] && m_prev_in[i] && (pin_dir[i] == m_prev_dir[i]);
        end
        // Filter flips when the last FILTER_CYCLES samples all disagree with it.
        sync_hist.push_back(now_sync);
        if (sync_hist.size() > FILTER_CYCLES) void'(sync_hist.pop_front());
        if (sync_hist.size() == FILTER_CYCLES) begin
            for (int i = 0; i < NPINS; i++) begin
                all_new = 1'b1;
                foreach (sync_hist[j]) if (sync_hist[j][i] == m_filt[i]) all_new = 1'b0;
                if (all_new) m_filt[i] = ~m_filt[i];
            end
        end
        pad_hist.push_back(pad_in);
        if (pad_hist.size() > SYNC_STAGES) void'(pad_hist.pop_front());
        m_prev_in  = now_in;
        m_prev_dir = pin_dir;
        m_pad_out  = pin_out;
        m_pad_oe   = pin_dir;
    endtask

    task automatic chk(input string tag, input logic [NPINS-1:0] obs, input logic [NPINS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pad_out"}, pad_out, m_pad_out);
        chk({tag, "_pad_oe"},  pad_oe,  m_pad_oe);
        chk({tag, "_pin_in"},  pin_in,  m_pin_in());
        chk({tag, "_rise"},    pin_rise, m_rise);
        chk({tag, "_fall"},    pin_fall, m_fall);
    endtask

    task automatic step(input string tag);
        @(posedge clock_160);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int lat;
        int pulses;
        bit found;

        inp_resn = 1'b0;
        pin_out  = '0;
        pin_dir  = '0;
        pad_in   = '0;
        model_reset();
        #2;
        check_all("reset");
        step("rst_hold");
        step("rst_hold");
        inp_resn = 1'b1;
        repeat (3) step("idle");

        // Mid-cycle reset drops the output enables before the next edge.
        pin_dir = '1;
        pin_out = 32'hA5C3_0F96;
        step("s1_drive");
        step("s1_drive");
        #3;
        inp_resn = 1'b0;
        model_reset();
        #1;
        chk("s1_oe_async", pad_oe, '0);
        check_all("s1_async");
        step("s1_rst");
        inp_resn = 1'b1;
        pin_dir  = '0;
        pin_out  = '0;
        repeat (3) step("s1_post");

        // Held pad change: latency and single rise pulse.
        pad_in[3] = 1'b1;
        lat   = 99;
        found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            step("s2_wait");
            if (pin_in[3]) begin
                lat   = n;
                found = 1'b1;
            end
        end
        chk("s2_latency", NPINS'(lat), NPINS'(LAT));
        step("s2_edge");
        chk("s2_rise", NPINS'(pin_rise[3]), NPINS'(1));
        chk("s2_fall", NPINS'(pin_fall[3]), NPINS'(0));
        step("s2_after");
        chk("s2_rise_end", NPINS'(pin_rise[3]), NPINS'(0));
        pad_in[3] = 1'b0;
        repeat (10) step("s2_settle");

        // Short pulses: 3 cycles is a glitch to the filter, 4 cycles passes.
        for (int w = 3; w <= 4; w++) begin
            pulses    = 0;
            pad_in[5] = 1'b1;
            for (int n = 0; n < w; n++) begin
                step("s3_pulse");
                pulses += int'(pin_rise[5]);
            end
            pad_in[5] = 1'b0;
            for (int n = 0; n < 14; n++) begin
                step("s3_settle");
                pulses += int'(pin_rise[5]);
            end
            chk(w == 3 ? "s3_short" : "s3_long", NPINS'(pulses),
                NPINS'((w == 3 && FILT_EN) ? 0 : 1));
        end

        // Output pin reads back its own data combinationally.
        pin_dir[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            pin_out[0] = ~pin_out[0];
            #1;
            chk("s4_readback", NPINS'(pin_in[0]), NPINS'(pin_out[0]));
            step("s4_step");
        end
        pin_dir[0] = 1'b0;

        // Switching to input exposes the settled pad level with no spurious edge.
        pad_in[7]  = 1'b1;
        pin_dir[7] = 1'b1;
        pin_out[7] = 1'b0;
        repeat (10) step("s5_settle");
        pin_dir[7] = 1'b0;
        #1;
        chk("s5_immediate", NPINS'(pin_in[7]), NPINS'(1));
        step("s5_switch");
        chk("s5_no_rise", NPINS'(pin_rise[7]), NPINS'(0));
        step("s5_after");
        chk("s5_no_rise2", NPINS'(pin_rise[7]), NPINS'(0));

        // Random traffic with occasional mid-cycle resets; pin 9 toggles every cycle.
        for (int c = 0; c < 600; c++) begin
            pad_in    = pad_in ^ ($urandom & $urandom & $urandom);
            pad_in[9] = c[0];
            pin_out   = $urandom;
            if ($urandom_range(0, 3) == 0) pin_dir = pin_dir ^ ($urandom & $urandom & $urandom);
            if (c % 150 == 149) begin
                #3;
                inp_resn = 1'b0;
                model_reset();
                #1;
                check_all("rnd_async");
                step("rnd_rst");
                inp_resn = 1'b1;
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
